// File: rtl/read_submodule_pkg.sv
// Shared types and constants for the read-side handshake initiator.
// State encodings use an RD_ prefix so they never collide with the write side.
package read_submodule_pkg;

  localparam int unsigned RD_STATE_WDTH = 2;

  typedef enum logic [RD_STATE_WDTH-1:0] {
    RD_IDLE     = 2'd0,
    RD_SEND_AR  = 2'd1,
    RD_WAIT_R   = 2'd2,
    RD_ERR_TRAP = 2'd3
  } rd_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // True while a transaction is outstanding on the bus.
  function automatic logic rd_is_busy(input rd_state_e st);
    return (st == RD_SEND_AR) || (st == RD_WAIT_R);
  endfunction

endpackage

// File: rtl/read_submodule_watchdog_counter.sv
// Saturating stall counter; expired is high once every bit is set.
// Shared with the write initiator, so it carries no read-specific logic.
module watchdog_counter
  import read_submodule_pkg::*;
#(
  parameter int unsigned TIMEOUT_WDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TIMEOUT_WDTH-1:0] cnt_q;
  logic [TIMEOUT_WDTH-1:0] cnt_d;

  assign expired = &cnt_q;

  // Next count: clear has priority; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {TIMEOUT_WDTH{1'b0}};
    end else if (inc && !expired) begin
      cnt_d = cnt_q + {{(TIMEOUT_WDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {TIMEOUT_WDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/read_submodule.sv
// Single-beat read initiator: one AR beat, one R beat, result held until the next read.
// A watchdog returns the FSM to IDLE if memory stalls either channel.
module read_submodule
  import read_submodule_pkg::*;
#(
  parameter int unsigned ADDR_WDTH    = 4,
  parameter int unsigned DATA_WDTH    = 32,
  parameter int unsigned RESP_WDTH    = 1,
  parameter int unsigned TIMEOUT_WDTH = 8,
  parameter bit          TIMEOUT_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  input  logic                 start,
  input  logic [ADDR_WDTH-1:0] addr,
  output logic                 done,
  output logic [DATA_WDTH-1:0] data,
  output logic [RESP_WDTH-1:0] resp,
  output logic                 timeout,
  output logic                 swich_case_default
);

  rd_state_e              state_q, state_d;
  logic [ADDR_WDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_WDTH-1:0]   data_q, data_d;
  logic [RESP_WDTH-1:0]   resp_q, resp_d;
  logic                   timeout_q, timeout_d;
  logic                   wd_clr_s;
  logic                   wd_inc_s;
  logic                   wd_expired_s;
  logic                   expired_s;

  watchdog_counter #(
    .TIMEOUT_WDTH(TIMEOUT_WDTH)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr_s),
    .inc    (wd_inc_s),
    .expired(wd_expired_s)
  );

  assign expired_s = TIMEOUT_EN ? wd_expired_s : 1'b0;

  // Next-state and capture logic; a handshake always beats an expiring counter.
  always_comb begin
    state_d    = state_q;
    reg_addr_d = reg_addr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    wd_clr_s   = 1'b0;
    wd_inc_s   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start) begin
          reg_addr_d = addr;
          timeout_d  = 1'b0;
          wd_clr_s   = 1'b1;
          state_d    = RD_SEND_AR;
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_SEND_AR: begin
        if (ar_ready) begin
          wd_clr_s = 1'b1;
          state_d  = RD_WAIT_R;
        end else if (expired_s) begin
          timeout_d = 1'b1;
          state_d   = RD_IDLE;
        end else begin
          wd_inc_s = 1'b1;
        end
      end
      RD_WAIT_R: begin
        if (r_valid) begin
          data_d  = r_data;
          resp_d  = r_resp;
          state_d = RD_IDLE;
        end else if (expired_s) begin
          timeout_d = 1'b1;
          state_d   = RD_IDLE;
        end else begin
          wd_inc_s = 1'b1;
        end
      end
      RD_ERR_TRAP: begin
        state_d = RD_ERR_TRAP;
      end
      default: begin
        state_d = RD_ERR_TRAP;
      end
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    ar_valid           = 1'b0;
    r_ready            = 1'b0;
    done               = 1'b0;
    swich_case_default = 1'b0;
    case (state_q)
      RD_IDLE:     done               = 1'b1;
      RD_SEND_AR:  ar_valid           = 1'b1;
      RD_WAIT_R:   r_ready            = 1'b1;
      RD_ERR_TRAP: swich_case_default = 1'b1;
      default:     swich_case_default = 1'b1;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      reg_addr_q <= {ADDR_WDTH{1'b0}};
      data_q     <= {DATA_WDTH{1'b0}};
      resp_q     <= {RESP_WDTH{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_addr_q <= reg_addr_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ar_address = reg_addr_q;
  assign data       = data_q;
  assign resp       = resp_q;
  assign timeout    = timeout_q;

endmodule
